// File: rtl/alu_decode_issue.sv
// Decode-and-issue stage: decodes RV32I OP/OP-IMM/LUI/AUIPC into ALU commands
// and holds them in a 2-entry registered skid buffer (main = head, skid = overflow).
module alu_decode_issue #(
  parameter int unsigned N_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [N_BITS-1:0] in_pc,
  input  logic [N_BITS-1:0] in_rs1_data,
  input  logic [N_BITS-1:0] in_rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_op,
  output logic [N_BITS-1:0] out_in0,
  output logic [N_BITS-1:0] out_in1,
  output logic [4:0]        out_rd,
  output logic              out_illegal
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  typedef struct packed {
    logic [3:0]        alu_op;
    logic [N_BITS-1:0] in0;
    logic [N_BITS-1:0] in1;
    logic [4:0]        rd;
    logic              illegal;
  } entry_t;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [N_BITS-1:0] imm_i;
  logic [N_BITS-1:0] imm_u;
  logic [N_BITS-1:0] shamt;
  logic              legal;
  entry_t            dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = N_BITS'($signed(in_instr[31:20]));
  assign imm_u  = N_BITS'($signed({in_instr[31:12], 12'b0}));
  assign shamt  = N_BITS'(in_instr[24:20]);

  always_comb begin
    dec    = '0;
    legal  = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        dec.alu_op = {funct3, (funct3 == 3'b000 || funct3 == 3'b101) ? in_instr[30] : 1'b0};
        dec.in0    = in_rs1_data;
        dec.in1    = in_rs2_data;
      end
      OPC_OP_IMM: begin
        dec.in0 = in_rs1_data;
        if (funct3 == 3'b001) begin
          legal      = (funct7 == 7'b0000000);
          dec.alu_op = {funct3, 1'b0};
          dec.in1    = shamt;
        end else if (funct3 == 3'b101) begin
          legal      = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          dec.alu_op = {funct3, in_instr[30]};
          dec.in1    = shamt;
        end else begin
          legal      = 1'b1;
          dec.alu_op = {funct3, 1'b0};
          dec.in1    = imm_i;
        end
      end
      OPC_LUI: begin
        legal   = 1'b1;
        dec.in1 = imm_u;
      end
      OPC_AUIPC: begin
        legal   = 1'b1;
        dec.in0 = in_pc;
        dec.in1 = imm_u;
      end
      default: legal = 1'b0;
    endcase
    // Illegal entries still issue, carrying only rd and the flag.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.rd = in_instr[11:7];
  end

  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   ready_q;
  logic   accept;
  logic   pop;

  assign accept = in_valid & ready_q;
  assign pop    = main_valid & out_ready;

  // ready_q always tracks ~skid_valid; accept is impossible while skid is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (skid_valid) begin
      if (pop) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
      end
    end else if (accept) begin
      if (!main_valid || pop) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
        ready_q    <= 1'b0;
      end
    end else if (pop) begin
      main_valid <= 1'b0;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = main_valid;
  assign out_alu_op  = main_q.alu_op;
  assign out_in0     = main_q.in0;
  assign out_in1     = main_q.in1;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_issue.sv
// Directed bench for alu_decode_issue: decode vector table plus backpressure,
// flush and reset sequences with hand-computed expectations.
module tb_alu_decode_issue;
  localparam int unsigned N = 32;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0]   in_instr;
  logic [N-1:0]  in_pc, in_rs1_data, in_rs2_data, out_in0, out_in1;
  logic [3:0]    out_alu_op;
  logic [4:0]    out_rd;

  int checks = 0;
  int errors = 0;

  alu_decode_issue #(.N_BITS(N)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_in0(out_in0), .out_in1(out_in1), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [3:0]  op;
    logic [31:0] in0, in1;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_entry(input string tag, input logic [3:0] op, input logic [31:0] i0,
                             input logic [31:0] i1, input logic [4:0] rd, input logic ill);
    check({tag, ".valid"},   64'(out_valid),   64'd1);
    check({tag, ".op"},      64'(out_alu_op),  64'(op));
    check({tag, ".in0"},     64'(out_in0),     64'(i0));
    check({tag, ".in1"},     64'(out_in1),     64'(i1));
    check({tag, ".rd"},      64'(out_rd),      64'(rd));
    check({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},   64'(out_valid),   64'd0);
    check({tag, ".ready"},   64'(in_ready),    64'd1);
    check({tag, ".op"},      64'(out_alu_op),  64'd0);
    check({tag, ".in0"},     64'(out_in0),     64'd0);
    check({tag, ".in1"},     64'(out_in1),     64'd0);
    check({tag, ".rd"},      64'(out_rd),      64'd0);
    check({tag, ".illegal"}, 64'(out_illegal), 64'd0);
  endtask

  initial begin
    //           instr          pc          rs1          rs2         op     in0          in1          rd     ill
    vecs.push_back('{32'h002081B3, 32'h0,     32'd5,        32'd7,     4'h0, 32'd5,        32'd7,        5'd3, 1'b0}); // add
    vecs.push_back('{32'h402081B3, 32'h0,     32'd5,        32'd7,     4'h1, 32'd5,        32'd7,        5'd3, 1'b0}); // sub
    vecs.push_back('{32'h40435293, 32'h0,     32'h80000000, 32'h55,    4'hB, 32'h80000000, 32'h4,        5'd5, 1'b0}); // srai
    vecs.push_back('{32'hFFF00093, 32'h0,     32'h0,        32'h9,     4'h0, 32'h0,        32'hFFFFFFFF, 5'd1, 1'b0}); // addi -1
    vecs.push_back('{32'h123453B7, 32'h40,    32'hDEAD,     32'hBEEF,  4'h0, 32'h0,        32'h12345000, 5'd7, 1'b0}); // lui
    vecs.push_back('{32'h00001097, 32'h100,   32'hDEAD,     32'hBEEF,  4'h0, 32'h100,      32'h1000,     5'd1, 1'b0}); // auipc
    vecs.push_back('{32'h0000006F, 32'h200,   32'h3,        32'h4,     4'h0, 32'h0,        32'h0,        5'd0, 1'b1}); // jal x0
    vecs.push_back('{32'h000000EF, 32'h200,   32'h3,        32'h4,     4'h0, 32'h0,        32'h0,        5'd1, 1'b1}); // jal x1
    vecs.push_back('{32'h420081B3, 32'h0,     32'h3,        32'h4,     4'h0, 32'h0,        32'h0,        5'd3, 1'b1}); // funct7 0100001
    vecs.push_back('{32'h0020C1B3, 32'h0,     32'hF0F0,     32'h0FF0,  4'h8, 32'hF0F0,     32'h0FF0,     5'd3, 1'b0}); // xor
    vecs.push_back('{32'h4020D1B3, 32'h0,     32'h11,       32'h2,     4'hB, 32'h11,       32'h2,        5'd3, 1'b0}); // sra
    vecs.push_back('{32'h4020B1B3, 32'h0,     32'h11,       32'h2,     4'h0, 32'h0,        32'h0,        5'd3, 1'b1}); // sltu w/ 0100000
    vecs.push_back('{32'h00331293, 32'h0,     32'h6,        32'h0,     4'h2, 32'h6,        32'h3,        5'd5, 1'b0}); // slli 3
    vecs.push_back('{32'h40331293, 32'h0,     32'h6,        32'h0,     4'h0, 32'h0,        32'h0,        5'd5, 1'b1}); // slli bad funct7
    vecs.push_back('{32'h01F35293, 32'h0,     32'h6,        32'h0,     4'hA, 32'h6,        32'd31,       5'd5, 1'b0}); // srli 31
    vecs.push_back('{32'h4000F113, 32'h0,     32'hFFFF,     32'h0,     4'hE, 32'hFFFF,     32'h400,      5'd2, 1'b0}); // andi bit30 set
    vecs.push_back('{32'h8000A113, 32'h0,     32'h1,        32'h0,     4'h4, 32'h1,        32'hFFFFF800, 5'd2, 1'b0}); // slti -2048
    vecs.push_back('{32'h0020A023, 32'h0,     32'h1,        32'h2,     4'h0, 32'h0,        32'h0,        5'd0, 1'b1}); // sw

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Table: one instruction per cycle, out_ready held high.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      tick();
      in_valid = 1'b0;
      check_entry($sformatf("vec%0d", i), vecs[i].op, vecs[i].in0, vecs[i].in1, vecs[i].rd, vecs[i].ill);
      check($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'd1);
    end
    tick();
    check("drain.valid", 64'(out_valid), 64'd0);

    // Backpressure: A, B held; C stalls until skid drains.
    out_ready = 1'b0;
    drive(32'h00100093, 32'h0, 32'h0, 32'h0);
    tick();
    check_entry("bp.A1", 4'h0, 32'h0, 32'h1, 5'd1, 1'b0);
    check("bp.ready1", 64'(in_ready), 64'd1);
    drive(32'h00200113, 32'h0, 32'h0, 32'h0);
    tick();
    check_entry("bp.A2", 4'h0, 32'h0, 32'h1, 5'd1, 1'b0);
    check("bp.ready2", 64'(in_ready), 64'd0);
    drive(32'h00300193, 32'h0, 32'h0, 32'h0);
    tick();
    check_entry("bp.A3", 4'h0, 32'h0, 32'h1, 5'd1, 1'b0);
    check("bp.ready3", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check_entry("bp.B", 4'h0, 32'h0, 32'h2, 5'd2, 1'b0);
    check("bp.ready4", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check_entry("bp.C", 4'h0, 32'h0, 32'h3, 5'd3, 1'b0);
    tick();
    check("bp.empty", 64'(out_valid), 64'd0);
    tick();
    check("bp.no_dup", 64'(out_valid), 64'd0);

    // Flush with two entries held and a new input pending.
    out_ready = 1'b0;
    drive(32'h00100093, 32'h0, 32'h0, 32'h0); tick();
    drive(32'h00200113, 32'h0, 32'h0, 32'h0); tick();
    check("fl2.ready_pre", 64'(in_ready), 64'd0);
    drive(32'h00400213, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl2.valid", 64'(out_valid), 64'd0);
    check("fl2.ready", 64'(in_ready), 64'd1);
    tick();
    check("fl2.no_ghost", 64'(out_valid), 64'd0);

    // Flush with one entry held: in_ready is 1 so the input must be dropped by flush itself.
    out_ready = 1'b0;
    drive(32'h00100093, 32'h0, 32'h0, 32'h0); tick();
    drive(32'h00400213, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl1.valid", 64'(out_valid), 64'd0);
    check("fl1.ready", 64'(in_ready), 64'd1);
    tick();
    check("fl1.no_ghost", 64'(out_valid), 64'd0);

    // Reset with two entries held (illegal head, lui in skid) and a new input pending.
    out_ready = 1'b0;
    drive(32'h420081B3, 32'h0, 32'h0, 32'h0); tick();
    drive(32'h123453B7, 32'h0, 32'h0, 32'h0); tick();
    check_entry("rs.head", 4'h0, 32'h0, 32'h0, 5'd3, 1'b1);
    drive(32'h00400213, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check_all_zero("rs");
    tick();
    check("rs.no_ghost", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_decode_issue.md
# alu_decode_issue

Decode-and-issue stage that produces the ALU's command stream. It accepts a fetched RV32I instruction with its register-file operands and PC, and decodes OP, OP-IMM, LUI and AUIPC into `alu_op`, `in0` and `in1` using the ALU's 4-bit op encoding. Results sit in a 2-entry registered skid buffer with valid/ready on both sides, between register read and the execute stage.

## Interface
- `N_BITS`, 32, datapath width; immediates are sign-extended to `N_BITS`; must be ≥ 32
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous discard of all buffered entries
- `in_valid`  in  1  upstream has an instruction
- `in_ready`  out  1  stage can accept; registered
- `in_instr`  in  32  RV32I instruction word
- `in_pc`  in  N_BITS  instruction PC
- `in_rs1_data`  in  N_BITS  rs1 value
- `in_rs2_data`  in  N_BITS  rs2 value
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  execute stage consumes the head entry
- `out_alu_op`  out  4  ALU operation
- `out_in0`  out  N_BITS  ALU operand 0
- `out_in1`  out  N_BITS  ALU operand 1
- `out_rd`  out  5  destination register (`instr[11:7]`)
- `out_illegal`  out  1  instruction is not an ALU-class instruction

## Operation
- ALU op encoding: ADD=0000, SUB=0001, SLL=0010, SLT=0100, SLTU=0110, XOR=1000, SRL=1010, SRA=1011, OR=1100, AND=1110.
- `alu_op[3:1]` is always `funct3` (`instr[14:12]`). `alu_op[0]` is `instr[30]` only for OP ADD/SUB, OP SRL/SRA and OP-IMM SRLI/SRAI. In all other cases it is 0.
- OP (opcode 0110011): `in0 = rs1`, `in1 = rs2`.
  - `funct7` must be 0000000.
  - 0100000 is also legal when `funct3` is 000 or 101.
  - Any other `funct7` is illegal.
- OP-IMM (opcode 0010011): `in0 = rs1`, `in1 = sext(instr[31:20])`.
  - For `funct3` 001 and 101, `in1 = zext(instr[24:20])`.
  - SLLI requires `instr[31:25]` = 0000000.
  - SRLI/SRAI requires `instr[31:25]` ∈ {0000000, 0100000}.
  - Any other value for these fields is illegal.
- LUI (opcode 0110111): op = ADD, `in0 = 0`, `in1 = sext({instr[31:12], 12'b0})`.
- AUIPC (opcode 0010111): op = ADD, `in0 = pc`, `in1 = sext({instr[31:12], 12'b0})`.
- Illegal handling:
  - Any other opcode, or a field violation listed above, sets `out_illegal = 1`, with `alu_op = 0000` and `in0 = in1 = 0`.
  - `rd` still passes through.
  - The entry is issued normally and is not dropped.
- Buffer structure: two entries, `main` (the head, drives the outputs) and `skid`. Occupancy is 0, 1 or 2. Decode is combinational on the input and is registered on accept.
- Accept happens when `in_valid & in_ready`. Pop happens when `out_valid & out_ready`.
- Per-edge update rules:
  - If `main` is empty, or is popped this cycle while `skid` is empty, the accepted entry is written into `main`.
  - If `main` is popped while `skid` is full, `skid` moves to `main`. `in_ready` was 0, so no accept occurs in that cycle.
  - Accept without pop while `main` is full writes the entry into `skid`.
- Order is strictly FIFO; no entry is lost or duplicated.
- `in_ready = ~skid_valid`, registered.
- Priority: `rst` > `flush` > accept/pop.
  - `flush` empties both entries.
  - An input presented in the flush cycle is discarded.
  - `in_ready` is not gated by `flush`.

## Timing
- Reset values: `out_valid = 0`, `in_ready = 1`, `out_alu_op = 0000`, `out_in0 = 0`, `out_in1 = 0`, `out_rd = 0`, `out_illegal = 0`.
- Latency: accepted at edge N, the entry is visible on the outputs with `out_valid = 1` after edge N.
- Throughput: one instruction per cycle with `out_ready` held high; `in_ready` stays 1.
- `in_ready` falls the cycle after `skid` fills. It rises the cycle after the first pop that empties `skid`.
- Output data is stable while `out_valid & ~out_ready`.
- Reset or flush mid-stream: both entries are empty after the edge, with `out_valid = 0` and `in_ready = 1` the next cycle.
- Simultaneous accept and pop with occupancy 1: occupancy stays 1, and the new entry is in `main` after the edge.

## Test plan
- Basic decode, issued one cycle after accept:
  - `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7 → op 0000, in0=5, in1=7, rd=3, illegal=0.
  - `sub` (0x402081B3) → op 0001.
- Shift immediate: `srai x5,x6,4` (0x40435293), rs1=0x80000000 → op 1011, in0=0x80000000, in1=0x00000004, rd=5.
- Immediates:
  - `addi x1,x0,-1` (0xFFF00093) → op 0000, in1=0xFFFFFFFF.
  - `lui x7,0x12345` (0x123453B7) → in0=0, in1=0x12345000.
  - `auipc x1,1` (0x00001097) with pc=0x100 → in0=0x100, in1=0x1000.
- Backpressure: hold `out_ready=0` and drive 3 back-to-back instructions → 2 accepted, `in_ready=0` from cycle 3. Raise `out_ready` → all 3 emerge in order, each exactly once.
- Illegal: JAL (0x0000006F) and `funct7`=0100001 OP (0x420081B3) → illegal=1, op 0000, in0=in1=0, rd passed through.
- Flush and reset:
  - With 2 entries held, assert `flush` while a new input is valid → next cycle `out_valid=0`, `in_ready=1`, and the flushed input never appears.
  - Repeat the same scenario with `rst` → same result, and all outputs are 0.
